// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART transmitter behind a valid/ready byte handshake
// SOut and DataInReady are both registered; a frame is 10 symbol periods from start to stop.
module uart_transmitter #(
  parameter int ClockFreq = 50_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] DataIn,
  input  logic       DataInValid,
  output logic       DataInReady,
  output logic       SOut
);

  localparam int SymbolEdgeTime    = ClockFreq / BaudRate;
  localparam int ClockCounterWidth = $clog2(SymbolEdgeTime);
  localparam logic [ClockCounterWidth-1:0] LastCount = ClockCounterWidth'(SymbolEdgeTime - 1);

  typedef enum logic {IDLE, TX} state_e;

  state_e                         state_q, state_d;
  logic [ClockCounterWidth-1:0]   count_q, count_d;
  logic [3:0]                     bit_idx_q, bit_idx_d;
  logic [9:0]                     shift_q, shift_d;
  logic                           ready_q, ready_d;
  logic                           sout_q, sout_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      ready_q   <= 1'b0;
      sout_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ready_q   <= ready_d;
      sout_q    <= sout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    ready_d   = 1'b0;
    sout_d    = sout_q;
    case (state_q)
      IDLE: begin
        sout_d  = 1'b1;
        ready_d = 1'b1;
        if (DataInValid && ready_q) begin
          state_d   = TX;
          count_d   = '0;
          bit_idx_d = 4'd0;
          shift_d   = {1'b1, DataIn, 1'b0};
          ready_d   = 1'b0;
          sout_d    = 1'b0;
        end
      end
      TX: begin
        sout_d = shift_q[0];
        if (count_q == LastCount) begin
          count_d = '0;
          if (bit_idx_q == 4'd9) begin
            // Stop bit done: ready and idle-high appear together on the next cycle.
            state_d = IDLE;
            ready_d = 1'b1;
            sout_d  = 1'b1;
          end else begin
            shift_d   = {1'b1, shift_q[9:1]};
            bit_idx_d = bit_idx_q + 4'd1;
            sout_d    = shift_q[1];
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign DataInReady = ready_q;
  assign SOut        = sout_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - directed table-driven bench for uart_transmitter
// Expected serial bit sequences are written out by hand, first-transmitted bit in the MSB.
module tb_uart_transmitter;

  localparam int T = 10;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       dv;
  logic       rdy;
  logic       sout;

  int vecs;
  int miscompares;

  uart_transmitter #(.ClockFreq(1000), .BaudRate(100)) dut (
    .Clock      (clk),
    .Reset      (rst),
    .DataIn     (din),
    .DataInValid(dv),
    .DataInReady(rdy),
    .SOut       (sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;
    int         mode;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start(input logic [7:0] d);
    int b;
    b = 0;
    @(negedge clk);
    din = d;
    dv  = 1'b1;
    while (rdy !== 1'b1 && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("start ready", {31'd0, rdy}, 32'd1);
    @(posedge clk);
  endtask

  // mode 0 plain, 1 scramble DataIn every cycle, 2 pulse a refused request mid-frame
  task automatic run_frame(input string name, input logic [9:0] exp, input int mode,
                           input logic keep_valid, input logic [7:0] next_din);
    int bad_hold;
    int rdy_high;
    int n;
    logic mid;
    rdy_high = 0;
    mid = 1'bx;
    for (int k = 0; k < 10; k++) begin
      bad_hold = 0;
      for (int c = 0; c < T; c++) begin
        @(negedge clk);
        n = k * T + c;
        if (sout !== exp[9-k]) bad_hold++;
        if (rdy !== 1'b0) rdy_high++;
        if (c == T / 2) mid = sout;
        if (n == 0) begin
          if (keep_valid) din = next_din;
          else dv = 1'b0;
        end
        if (mode == 1) din = 8'($urandom);
        if (mode == 2 && n == 35) begin dv = 1'b1; din = 8'h3C; end
        if (mode == 2 && n == 36) dv = 1'b0;
      end
      check($sformatf("%s bit%0d mid", name, k), {31'd0, mid}, {31'd0, exp[9-k]});
      check($sformatf("%s bit%0d hold", name, k), bad_hold, 0);
    end
    check($sformatf("%s ready low in frame", name), rdy_high, 0);
    @(negedge clk);
    check($sformatf("%s ready after stop", name), {31'd0, rdy}, 32'd1);
    check($sformatf("%s idle after stop", name), {31'd0, sout}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[3];
    int   bad;
    logic [9:0] exp5a;
    vecs        = 0;
    miscompares = 0;

    tbl[0] = '{data: 8'hA5, bits: 10'b0101001011, mode: 0};
    tbl[1] = '{data: 8'hC3, bits: 10'b0110000111, mode: 1};
    tbl[2] = '{data: 8'h69, bits: 10'b0100101101, mode: 2};

    rst = 1'b1;
    dv  = 1'b1;
    din = 8'h00;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("reset sout", {31'd0, sout}, 32'd1);
      check("reset ready", {31'd0, rdy}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("ready after reset", {31'd0, rdy}, 32'd1);
    check("sout after reset", {31'd0, sout}, 32'd1);
    dv = 1'b0;

    for (int i = 0; i < 3; i++) begin
      start(tbl[i].data);
      run_frame($sformatf("vec%0d", i), tbl[i].bits, tbl[i].mode, 1'b0, 8'h00);
      if (tbl[i].mode == 2) begin
        bad = 0;
        repeat (30) begin
          @(negedge clk);
          if (sout !== 1'b1 || rdy !== 1'b1) bad++;
        end
        check("no extra frame", bad, 0);
      end
    end

    start(8'h00);
    run_frame("b2b first", 10'b0000000001, 0, 1'b1, 8'hFF);
    @(posedge clk);
    run_frame("b2b second", 10'b0111111111, 0, 1'b0, 8'h00);

    exp5a = 10'b0010110101;
    start(8'h5A);
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      if (n == 0) dv = 1'b0;
      if (n % T == T / 2) check($sformatf("5A bit%0d", n / T), {31'd0, sout}, {31'd0, exp5a[9 - n / T]});
      if (n == 44) rst = 1'b1;
    end
    repeat (2) begin
      @(negedge clk);
      check("midframe reset sout", {31'd0, sout}, 32'd1);
      check("midframe reset ready", {31'd0, rdy}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("ready after midframe reset", {31'd0, rdy}, 32'd1);
    check("sout after midframe reset", {31'd0, sout}, 32'd1);
    start(8'h81);
    run_frame("post-reset 81", 10'b0100000011, 0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
